// File: rtl/dw_slice_packer_if.sv
// Slice packer bus: narrow-slice input stream and wide-word output stream.
// master drives slices and out_ready; slave is the packer. in_sel exists with SLICE_PACK_SEL_EN.
interface dw_slice_packer_if #(
    parameter int OUT_width   = 8,
    parameter int SLICE_width = 2
);
    localparam int NUM_SLICES = (OUT_width + SLICE_width - 1) / SLICE_width;
    localparam int CNT_width  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES + 1) : 1;
    localparam int SEL_width  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [SLICE_width-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_width-1:0]   out_data;
    logic [CNT_width-1:0]   out_count;
`ifdef SLICE_PACK_SEL_EN
    logic [SEL_width-1:0]   in_sel;

    modport master (
        output in_valid, in_data, in_last, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_data, in_last, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`endif
endinterface

// File: rtl/dw_slice_packer.sv
// Builds an OUT_width word from SLICE_width slices; ports: HCLK, HRESET, bus (slave).
// SLICE_PACK_SEL_EN: slices go to index in_sel, tracked by a written mask.
module dw_slice_packer #(
    parameter int OUT_width   = 8,
    parameter int SLICE_width = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    dw_slice_packer_if.slave  bus
);
    localparam int NUM_SLICES = (OUT_width + SLICE_width - 1) / SLICE_width;
    localparam int CNT_width  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES + 1) : 1;
    localparam int SEL_width  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]           state;
    logic [OUT_width-1:0] data_q;
    logic [OUT_width-1:0] data_n;
    logic [CNT_width-1:0] cnt_q;
    logic [SEL_width-1:0] idx;
    logic                 hit;
    logic                 fresh;
    logic                 done;
    logic                 accept;

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_count = cnt_q;
    assign accept        = bus.in_valid && (state == FILL);

`ifdef SLICE_PACK_SEL_EN
    logic [NUM_SLICES-1:0] mask_q;
    logic [NUM_SLICES-1:0] mask_n;

    always_comb begin
        idx    = bus.in_sel;
        hit    = (32'(idx) < NUM_SLICES);
        mask_n = mask_q;
        fresh  = 1'b0;
        if (hit) begin
            fresh       = !mask_q[idx];
            mask_n[idx] = 1'b1;
        end
        done = (&mask_n) || bus.in_last;
    end
`else
    always_comb begin
        // Sequential mode: the slice count doubles as the write pointer.
        idx   = SEL_width'(cnt_q);
        hit   = 1'b1;
        fresh = 1'b1;
        done  = (32'(cnt_q) == NUM_SLICES - 1) || bus.in_last;
    end
`endif

    // Walk the output bits so indices past OUT_width never exist.
    always_comb begin
        data_n = data_q;
        for (int b = 0; b < OUT_width; b++) begin
            if (hit && (32'(idx) == b / SLICE_width))
                data_n[b] = bus.in_data[b % SLICE_width];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state  <= FILL;
            data_q <= '0;
            cnt_q  <= '0;
`ifdef SLICE_PACK_SEL_EN
            mask_q <= '0;
`endif
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        data_q <= data_n;
                        if (fresh)
                            cnt_q <= cnt_q + CNT_width'(1);
`ifdef SLICE_PACK_SEL_EN
                        mask_q <= mask_n;
`endif
                        if (done)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state  <= FILL;
                        data_q <= '0;
                        cnt_q  <= '0;
`ifdef SLICE_PACK_SEL_EN
                        mask_q <= '0;
`endif
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_dw_slice_packer.sv
// Directed self-checking bench for dw_slice_packer.
// Covers 8/2, 7/2 and 3/4 builds; select-mode sequences with SLICE_PACK_SEL_EN.
module tb_dw_slice_packer;
    logic HCLK = 1'b0;
    logic HRESET;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 HCLK = ~HCLK;

    dw_slice_packer_if #(.OUT_width(8), .SLICE_width(2)) a_if ();
    dw_slice_packer_if #(.OUT_width(7), .SLICE_width(2)) b_if ();
    dw_slice_packer_if #(.OUT_width(3), .SLICE_width(4)) d_if ();

    dw_slice_packer #(.OUT_width(8), .SLICE_width(2)) u_a (
        .HCLK(HCLK), .HRESET(HRESET), .bus(a_if));
    dw_slice_packer #(.OUT_width(7), .SLICE_width(2)) u_b (
        .HCLK(HCLK), .HRESET(HRESET), .bus(b_if));
    dw_slice_packer #(.OUT_width(3), .SLICE_width(4)) u_d (
        .HCLK(HCLK), .HRESET(HRESET), .bus(d_if));

`ifdef SLICE_PACK_SEL_EN
    dw_slice_packer_if #(.OUT_width(10), .SLICE_width(2)) c_if ();
    dw_slice_packer #(.OUT_width(10), .SLICE_width(2)) u_c (
        .HCLK(HCLK), .HRESET(HRESET), .bus(c_if));
`endif

    typedef struct {
        logic       vin;
        logic [1:0] din;
        logic       lin;
        logic [1:0] sel;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [2:0] oc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic vin, input logic [1:0] din, input logic lin,
        input logic [1:0] sel, input logic ordy, input logic ir,
        input logic ov, input logic [7:0] od, input logic [2:0] oc);
        vec_t v;
        v.vin = vin; v.din = din; v.lin = lin; v.sel = sel;
        v.ordy = ordy; v.ir = ir; v.ov = ov; v.od = od; v.oc = oc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_a(input logic vin, input logic [1:0] din,
                           input logic lin, input logic [1:0] sel,
                           input logic ordy);
        a_if.in_valid  = vin;
        a_if.in_data   = din;
        a_if.in_last   = lin;
        a_if.out_ready = ordy;
`ifdef SLICE_PACK_SEL_EN
        a_if.in_sel    = sel;
`else
        if (sel != 2'd0) begin end
`endif
    endtask

    task automatic chk_a(input string tag, input logic ir, input logic ov,
                         input logic [7:0] od, input logic [2:0] oc);
        chk({tag, " in_ready"}, 32'(a_if.in_ready), 32'(ir));
        chk({tag, " out_valid"}, 32'(a_if.out_valid), 32'(ov));
        chk({tag, " out_data"}, 32'(a_if.out_data), 32'(od));
        chk({tag, " out_count"}, 32'(a_if.out_count), 32'(oc));
    endtask

    initial begin
        HRESET = 1'b1;
        drive_a(1'b0, 2'b00, 1'b0, 2'd0, 1'b0);
        b_if.in_valid = 1'b0; b_if.in_data = '0;
        b_if.in_last = 1'b0; b_if.out_ready = 1'b0;
        d_if.in_valid = 1'b0; d_if.in_data = '0;
        d_if.in_last = 1'b0; d_if.out_ready = 1'b0;
`ifdef SLICE_PACK_SEL_EN
        b_if.in_sel = '0;
        d_if.in_sel = '0;
        c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.in_sel = '0;
        c_if.in_last = 1'b0; c_if.out_ready = 1'b0;
`endif
        tick();
        tick();
        chk_a("rst a", 1'b1, 1'b0, 8'h00, 3'd0);
        chk("rst b in_ready", 32'(b_if.in_ready), 32'd1);
        chk("rst b out_valid", 32'(b_if.out_valid), 32'd0);
        chk("rst d out_data", 32'(d_if.out_data), 32'd0);
        chk("rst d out_count", 32'(d_if.out_count), 32'd0);
        HRESET = 1'b0;

        // Full word 01,10,11,00 -> 39, then 5 held cycles with ignored pulses.
        tv.push_back(mk(1, 2'b01, 0, 2'd0, 0, 1, 0, 8'h01, 3'd1));
        tv.push_back(mk(1, 2'b10, 0, 2'd1, 0, 1, 0, 8'h09, 3'd2));
        tv.push_back(mk(1, 2'b11, 0, 2'd2, 0, 1, 0, 8'h39, 3'd3));
        tv.push_back(mk(1, 2'b00, 0, 2'd3, 0, 0, 1, 8'h39, 3'd4));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(1, 2'b11, 0, 2'd0, 0, 0, 1, 8'h39, 3'd4));
        tv.push_back(mk(0, 2'b00, 0, 2'd0, 1, 1, 0, 8'h00, 3'd0));
        tv.push_back(mk(0, 2'b11, 0, 2'd0, 1, 1, 0, 8'h00, 3'd0));
        // Early completion on in_last.
        tv.push_back(mk(1, 2'b01, 0, 2'd0, 0, 1, 0, 8'h01, 3'd1));
        tv.push_back(mk(1, 2'b10, 1, 2'd1, 0, 0, 1, 8'h09, 3'd2));
        tv.push_back(mk(0, 2'b00, 0, 2'd0, 1, 1, 0, 8'h00, 3'd0));
        // Single-slice word; in_valid in the release cycle is ignored.
        tv.push_back(mk(1, 2'b11, 1, 2'd0, 0, 0, 1, 8'h03, 3'd1));
        tv.push_back(mk(1, 2'b10, 0, 2'd0, 1, 1, 0, 8'h00, 3'd0));
        tv.push_back(mk(1, 2'b10, 0, 2'd0, 0, 1, 0, 8'h02, 3'd1));
        tv.push_back(mk(1, 2'b01, 1, 2'd1, 0, 0, 1, 8'h06, 3'd2));
        tv.push_back(mk(0, 2'b00, 0, 2'd0, 1, 1, 0, 8'h00, 3'd0));

        for (int i = 0; i < tv.size(); i++) begin
            drive_a(tv[i].vin, tv[i].din, tv[i].lin, tv[i].sel, tv[i].ordy);
            tick();
            chk_a($sformatf("vec%0d", i), tv[i].ir, tv[i].ov, tv[i].od, tv[i].oc);
        end

        // Reset mid-word discards the partial word.
        drive_a(1, 2'b01, 0, 2'd0, 0); tick();
        drive_a(1, 2'b10, 0, 2'd1, 0); tick();
        chk_a("pre rst", 1'b1, 1'b0, 8'h09, 3'd2);
        drive_a(0, 2'b00, 0, 2'd0, 0);
        HRESET = 1'b1; tick();
        HRESET = 1'b0;
        chk_a("mid rst", 1'b1, 1'b0, 8'h00, 3'd0);
        for (int i = 0; i < 4; i++) begin
            drive_a(1, 2'b11, 0, 2'(i), 0);
            tick();
        end
        chk_a("post rst", 1'b0, 1'b1, 8'hFF, 3'd4);
        drive_a(0, 2'b00, 0, 2'd0, 1); tick();
        chk_a("post rst rel", 1'b1, 1'b0, 8'h00, 3'd0);
        drive_a(0, 2'b00, 0, 2'd0, 0);

        // 7-bit word: the top bit of the last slice is dropped.
        for (int i = 0; i < 4; i++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = 2'b11;
`ifdef SLICE_PACK_SEL_EN
            b_if.in_sel   = 2'(i);
`endif
            tick();
            if (i == 2) begin
                chk("b partial data", 32'(b_if.out_data), 32'h3F);
                chk("b partial valid", 32'(b_if.out_valid), 32'd0);
            end
        end
        b_if.in_valid = 1'b0;
        chk("b out_data", 32'(b_if.out_data), 32'h7F);
        chk("b out_count", 32'(b_if.out_count), 32'd4);
        chk("b out_valid", 32'(b_if.out_valid), 32'd1);

        // One slice per word, truncated to 3 bits.
        d_if.in_valid = 1'b1;
        d_if.in_data  = 4'b1101;
        tick();
        d_if.in_valid = 1'b0;
        chk("d out_data", 32'(d_if.out_data), 32'h5);
        chk("d out_count", 32'(d_if.out_count), 32'd1);
        chk("d out_valid", 32'(d_if.out_valid), 32'd1);
        chk("d in_ready", 32'(d_if.in_ready), 32'd0);
        d_if.out_ready = 1'b1;
        tick();
        chk("d rel data", 32'(d_if.out_data), 32'h0);
        chk("d rel ready", 32'(d_if.in_ready), 32'd1);

`ifdef SLICE_PACK_SEL_EN
        begin
            logic [1:0] s_sel [5];
            logic [1:0] s_dat [5];
            logic [7:0] s_od  [5];
            logic [2:0] s_oc  [5];
            s_sel = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
            s_dat = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
            s_od  = '{8'hC0, 8'hC1, 8'hE1, 8'hE0, 8'hE8};
            s_oc  = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
            for (int i = 0; i < 5; i++) begin
                drive_a(1, s_dat[i], 0, s_sel[i], 0);
                tick();
                chk_a($sformatf("sel%0d", i), (i == 4) ? 1'b0 : 1'b1,
                      (i == 4) ? 1'b1 : 1'b0, s_od[i], s_oc[i]);
            end
            drive_a(0, 2'b00, 0, 2'd0, 1); tick();
            chk_a("sel rel", 1'b1, 1'b0, 8'h00, 3'd0);
        end
        c_if.in_valid = 1'b1;
        c_if.in_data = 2'b01; c_if.in_sel = 3'd0; tick();
        chk("c w0 data", 32'(c_if.out_data), 32'h001);
        c_if.in_data = 2'b11; c_if.in_sel = 3'd5; tick();
        chk("c sel5 data", 32'(c_if.out_data), 32'h001);
        chk("c sel5 count", 32'(c_if.out_count), 32'd1);
        c_if.in_sel = 3'd7; tick();
        chk("c sel7 data", 32'(c_if.out_data), 32'h001);
        chk("c sel7 valid", 32'(c_if.out_valid), 32'd0);
        c_if.in_sel = 3'd4; tick();
        chk("c w4 data", 32'(c_if.out_data), 32'h301);
        chk("c w4 count", 32'(c_if.out_count), 32'd2);
        c_if.in_sel = 3'd6; c_if.in_last = 1'b1; tick();
        c_if.in_valid = 1'b0; c_if.in_last = 1'b0;
        chk("c last valid", 32'(c_if.out_valid), 32'd1);
        chk("c last data", 32'(c_if.out_data), 32'h301);
        chk("c last count", 32'(c_if.out_count), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
